// File: rtl/noc_pkg.sv
// Shared NoC packet layout: field positions and widths used by the network interface, router and TX arbiter.
package noc_pkg;

  localparam int unsigned PKT_WIDTH         = 32;
  localparam int unsigned DEST_ROUTER_WIDTH = 4;
  localparam int unsigned DEST_NEURON_WIDTH = 12;
  localparam int unsigned PAYLOAD_WIDTH     = 16;
  localparam int unsigned DEST_ROUTER_LSB   = 28;
  localparam int unsigned DEST_NEURON_LSB   = 16;

  typedef struct packed {
    logic [DEST_ROUTER_WIDTH-1:0] dest_router;
    logic [DEST_NEURON_WIDTH-1:0] dest_neuron;
    logic [PAYLOAD_WIDTH-1:0]     payload;
  } noc_pkt_t;

  // Round-robin successor of a grant index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = (32'(ptr_i) + off) % N;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/noc_tx_arbiter.sv
// Round-robin share of the single NI TX port among NUM_REQ spike sources, with one registered
// output stage towards the router and a saturating sent-packet counter.
module noc_tx_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned ROUTER_ADDR_WIDTH = noc_pkg::DEST_ROUTER_WIDTH,
  parameter int unsigned NEURON_ADDR_WIDTH = noc_pkg::DEST_NEURON_WIDTH,
  parameter int unsigned PKT_WIDTH         = noc_pkg::PKT_WIDTH,
  parameter int unsigned CNT_WIDTH         = 16,
  parameter int unsigned IDX_WIDTH         = $clog2(NUM_REQ)
) (
  input  logic                           net_clk,
  input  logic                           net_rst,
  input  logic [NUM_REQ*PKT_WIDTH-1:0]   req_packet,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_en,
  output logic [PKT_WIDTH-1:0]           net_tx_packet,
  output logic                           net_tx_valid,
  input  logic                           net_tx_ready,
  output logic [IDX_WIDTH-1:0]           last_grant,
  output logic [CNT_WIDTH-1:0]           tx_count
);

  import noc_pkg::*;

  // Header fields plus payload must tile the packet exactly; catch bad overrides at elaboration.
  if (ROUTER_ADDR_WIDTH + NEURON_ADDR_WIDTH + PAYLOAD_WIDTH != PKT_WIDTH ||
      NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_params
    $error("noc_tx_arbiter: inconsistent parameters");
  end

  logic [PKT_WIDTH-1:0] pkt_q,   pkt_d;
  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] ptr_q,   ptr_d;
  logic [IDX_WIDTH-1:0] last_q,  last_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic                 load_c;
  logic [NUM_REQ-1:0]   elig_c;
  logic [NUM_REQ-1:0]   gnt_c;
  logic [IDX_WIDTH-1:0] gnt_idx_c;
  logic                 any_c;
  logic [PKT_WIDTH-1:0] pkt_sel_c;

  assign load_c = !valid_q || net_tx_ready;
  assign elig_c = req_valid & req_en;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_WIDTH)
  ) u_rr (
    .req_i (elig_c),
    .ptr_i (ptr_q),
    .gnt_o (gnt_c),
    .idx_o (gnt_idx_c),
    .any_o (any_c)
  );

  // One-hot AND-OR packet mux keeps the select free of variable part-selects.
  always_comb begin
    pkt_sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) pkt_sel_c = pkt_sel_c | req_packet[i*PKT_WIDTH +: PKT_WIDTH];
    end
  end

  assign req_ready = (load_c && !net_rst) ? gnt_c : '0;

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (load_c) begin
      if (any_c) begin
        pkt_d   = pkt_sel_c;
        valid_d = 1'b1;
        last_d  = gnt_idx_c;
        ptr_d   = IDX_WIDTH'(rr_next(32'(gnt_idx_c), NUM_REQ));
      end else begin
        valid_d = 1'b0;
      end
    end
    if (valid_q && net_tx_ready && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge net_clk) begin
    if (net_rst) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign net_tx_packet = pkt_q;
  assign net_tx_valid  = valid_q;
  assign last_grant    = last_q;
  assign tx_count      = cnt_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed bench for noc_tx_arbiter: a 16-bit-counter instance plus a 4-bit-counter instance on shared inputs.
module tb_noc_tx_arbiter;

  logic         net_clk = 1'b0;
  logic         net_rst;
  logic [127:0] req_packet;
  logic [3:0]   req_valid;
  logic [3:0]   req_en;
  logic         net_tx_ready;

  logic [3:0]   req_ready;
  logic [31:0]  net_tx_packet;
  logic         net_tx_valid;
  logic [1:0]   last_grant;
  logic [15:0]  tx_count;

  logic [3:0]   s_req_ready;
  logic [31:0]  s_net_tx_packet;
  logic         s_net_tx_valid;
  logic [1:0]   s_last_grant;
  logic [3:0]   s_tx_count;

  int checks = 0;
  int errors = 0;

  always #5 net_clk = ~net_clk;

  noc_tx_arbiter #(.NUM_REQ(4), .CNT_WIDTH(16)) dut (
    .net_clk       (net_clk),
    .net_rst       (net_rst),
    .req_packet    (req_packet),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_en        (req_en),
    .net_tx_packet (net_tx_packet),
    .net_tx_valid  (net_tx_valid),
    .net_tx_ready  (net_tx_ready),
    .last_grant    (last_grant),
    .tx_count      (tx_count)
  );

  noc_tx_arbiter #(.NUM_REQ(4), .CNT_WIDTH(4)) dut_sat (
    .net_clk       (net_clk),
    .net_rst       (net_rst),
    .req_packet    (req_packet),
    .req_valid     (req_valid),
    .req_ready     (s_req_ready),
    .req_en        (req_en),
    .net_tx_packet (s_net_tx_packet),
    .net_tx_valid  (s_net_tx_valid),
    .net_tx_ready  (net_tx_ready),
    .last_grant    (s_last_grant),
    .tx_count      (s_tx_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge net_clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic [31:0] v);
    req_packet[i*32 +: 32] = v;
  endtask

  task automatic set_all_pkts();
    for (int i = 0; i < 4; i++) set_pkt(i, 32'hC0DE_0000 + 32'(i));
  endtask

  task automatic do_reset();
    net_rst = 1'b1;
    tick();
    net_rst = 1'b0;
  endtask

  initial begin
    int order4 [5];
    order4 = '{0, 1, 3, 0, 1};

    // Reset: requesters all valid, but nothing may be acknowledged while reset is high.
    net_rst      = 1'b1;
    req_packet   = '0;
    req_valid    = 4'hF;
    req_en       = 4'hF;
    net_tx_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(net_tx_valid), 32'h0);
    check("rst_packet", net_tx_packet, 32'h0);
    check("rst_last_grant", 32'(last_grant), 32'h0);
    check("rst_tx_count", 32'(tx_count), 32'h0);
    check("rst_sat_count", 32'(s_tx_count), 32'h0);

    // 1. Single requester
    net_rst   = 1'b0;
    req_valid = 4'b0001;
    set_pkt(0, 32'h1234_5678);
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("t1_valid", 32'(net_tx_valid), 32'h1);
    check("t1_packet", net_tx_packet, 32'h1234_5678);
    check("t1_last_grant", 32'(last_grant), 32'h0);
    check("t1_count_pre", 32'(tx_count), 32'h0);
    #1;
    check("t1_idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("t1_count", 32'(tx_count), 32'h1);
    check("t1_valid_drop", 32'(net_tx_valid), 32'h0);
    check("t1_packet_hold", net_tx_packet, 32'h1234_5678);

    // 2. All four valid from reset: strict rotation, one packet per cycle
    do_reset();
    set_all_pkts();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_req_ready", 32'(req_ready), 32'(1) << (k % 4));
      tick();
      check("t2_valid", 32'(net_tx_valid), 32'h1);
      check("t2_packet", net_tx_packet, 32'hC0DE_0000 + 32'(k % 4));
      check("t2_last_grant", 32'(last_grant), 32'(k % 4));
    end
    check("t2_count", 32'(tx_count), 32'd5);

    // 3. Backpressure holds the output stable and blocks new grants
    do_reset();
    set_pkt(0, 32'hABCD_EF01);
    set_pkt(1, 32'h1111_0001);
    req_valid    = 4'b0011;
    net_tx_ready = 1'b1;
    tick();
    req_valid    = 4'b0010;
    net_tx_ready = 1'b0;
    check("t3_loaded", net_tx_packet, 32'hABCD_EF01);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_bp_req_ready", 32'(req_ready), 32'h0);
      tick();
      check("t3_bp_packet", net_tx_packet, 32'hABCD_EF01);
      check("t3_bp_valid", 32'(net_tx_valid), 32'h1);
    end
    check("t3_bp_count", 32'(tx_count), 32'h0);
    net_tx_ready = 1'b1;
    #1;
    check("t3_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    check("t3_next_packet", net_tx_packet, 32'h1111_0001);
    check("t3_next_grant", 32'(last_grant), 32'h1);
    check("t3_count", 32'(tx_count), 32'h1);

    // 4. Masked requester 2 is skipped
    do_reset();
    set_all_pkts();
    req_en    = 4'b1011;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_req_ready", 32'(req_ready), 32'(1) << order4[k]);
      tick();
      check("t4_packet", net_tx_packet, 32'hC0DE_0000 + 32'(order4[k]));
      check("t4_last_grant", 32'(last_grant), 32'(order4[k]));
    end
    check("t4_count", 32'(tx_count), 32'd4);

    // 5. Reset while a packet is held under backpressure
    net_tx_ready = 1'b0;
    tick();
    check("t5_held_valid", 32'(net_tx_valid), 32'h1);
    check("t5_held_count", 32'(tx_count), 32'd4);
    net_rst = 1'b1;
    #1;
    check("t5_rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    check("t5_valid", 32'(net_tx_valid), 32'h0);
    check("t5_count", 32'(tx_count), 32'h0);
    check("t5_packet", net_tx_packet, 32'h0);
    net_rst      = 1'b0;
    req_en       = 4'hF;
    net_tx_ready = 1'b1;
    #1;
    check("t5_restart_ready", 32'(req_ready), 32'h1);
    tick();
    check("t5_restart_grant", 32'(last_grant), 32'h0);
    check("t5_sat_start", 32'(s_tx_count), 32'h0);

    // 6. Saturating 4-bit counter over 20 handshakes
    for (int k = 0; k < 14; k++) tick();
    check("t6_sat_14", 32'(s_tx_count), 32'hE);
    tick();
    check("t6_sat_15", 32'(s_tx_count), 32'hF);
    for (int k = 0; k < 5; k++) tick();
    check("t6_sat_20", 32'(s_tx_count), 32'hF);
    check("t6_wide_20", 32'(tx_count), 32'd20);
    check("t6_sat_grant", 32'(s_last_grant), 32'(20 % 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
